// File: rtl/alu_seq_ctrl_if.sv
// Handshake, status and strobe bundle between the ALU datapath and its sequencer.
// ALU_SEQ_DIVZERO_EN adds the m_zero status and the div_err flag.
interface alu_seq_ctrl_if;
   logic        start;
   logic [1:0]  op_codes;
   logic        q_zero;
   logic        q_minus_one;
   logic        a_msb;
   logic        busy;
   logic        finish;
   logic [11:0] c;
`ifdef ALU_SEQ_DIVZERO_EN
   logic        m_zero;
   logic        div_err;

   modport master (
      output start, op_codes, q_zero, q_minus_one, a_msb, m_zero,
      input  busy, finish, c, div_err
   );
   modport slave (
      input  start, op_codes, q_zero, q_minus_one, a_msb, m_zero,
      output busy, finish, c, div_err
   );
`else
   modport master (
      output start, op_codes, q_zero, q_minus_one, a_msb,
      input  busy, finish, c
   );
   modport slave (
      input  start, op_codes, q_zero, q_minus_one, a_msb,
      output busy, finish, c
   );
`endif
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequencer for the multi-cycle ALU (ADD, SUB, Booth MUL, non-restoring DIV) with iteration counter.
// Optional ALU_SEQ_DIVZERO_EN: divide-by-zero short-circuits to a one-cycle ERR state with div_err.
module alu_seq_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst,
   alu_seq_ctrl_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH);

   localparam int C_CLR_A   = 0;
   localparam int C_LD_M    = 1;
   localparam int C_LD_Q    = 2;
   localparam int C_ADD     = 3;
   localparam int C_SUB     = 4;
   localparam int C_ASHR    = 5;
   localparam int C_SHL     = 6;
   localparam int C_SET_Q0  = 7;
   localparam int C_CNT_INC = 8;
   localparam int C_OUT_A   = 9;
   localparam int C_OUT_Q   = 10;
   localparam int C_CLR_CNT = 11;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   typedef enum logic [3:0] {
      S_IDLE, S_INIT, S_EXEC, S_MSTEP, S_MSHIFT, S_DSHIFT,
      S_DOP, S_DSET, S_DFIX, S_OUT_HI, S_OUT_LO, S_ERR
   } state_t;

   state_t           state, state_nxt;
   logic [1:0]       op;
   logic [CNT_W-1:0] cnt;
   logic             cnt_last;
   logic [11:0]      c_nxt;
   logic             fin_nxt;

   assign cnt_last = (cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         op    <= 2'b00;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE && bus.start)
            op <= bus.op_codes;
         // CLR_CNT wins; the terminating increment wraps back to zero
         if (c_nxt[C_CLR_CNT])
            cnt <= '0;
         else if (c_nxt[C_CNT_INC])
            cnt <= cnt_last ? '0 : cnt + CNT_W'(1);
      end
   end

   always_comb begin
      state_nxt = state;
      c_nxt     = '0;
      fin_nxt   = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (bus.start)
               state_nxt = S_INIT;
         end
         S_INIT: begin
            c_nxt[C_CLR_A]   = 1'b1;
            c_nxt[C_LD_M]    = 1'b1;
            c_nxt[C_LD_Q]    = 1'b1;
            c_nxt[C_CLR_CNT] = 1'b1;
            unique case (op)
               OP_ADD, OP_SUB: state_nxt = S_EXEC;
               OP_MUL:         state_nxt = S_MSTEP;
               default: begin
`ifdef ALU_SEQ_DIVZERO_EN
                  state_nxt = bus.m_zero ? S_ERR : S_DSHIFT;
`else
                  state_nxt = S_DSHIFT;
`endif
               end
            endcase
         end
         S_EXEC: begin
            if (op == OP_SUB)
               c_nxt[C_SUB] = 1'b1;
            else
               c_nxt[C_ADD] = 1'b1;
            state_nxt = S_OUT_HI;
         end
         S_MSTEP: begin
            // Booth recoding on {Q[0], q[-1]}: 10 subtracts, 01 adds
            if (bus.q_zero && !bus.q_minus_one)
               c_nxt[C_SUB] = 1'b1;
            else if (!bus.q_zero && bus.q_minus_one)
               c_nxt[C_ADD] = 1'b1;
            state_nxt = S_MSHIFT;
         end
         S_MSHIFT: begin
            c_nxt[C_ASHR]    = 1'b1;
            c_nxt[C_CNT_INC] = 1'b1;
            state_nxt = cnt_last ? S_OUT_HI : S_MSTEP;
         end
         S_DSHIFT: begin
            c_nxt[C_SHL] = 1'b1;
            state_nxt = S_DOP;
         end
         S_DOP: begin
            if (bus.a_msb)
               c_nxt[C_ADD] = 1'b1;
            else
               c_nxt[C_SUB] = 1'b1;
            state_nxt = S_DSET;
         end
         S_DSET: begin
            c_nxt[C_CNT_INC] = 1'b1;
            c_nxt[C_SET_Q0]  = !bus.a_msb;
            state_nxt = cnt_last ? S_DFIX : S_DSHIFT;
         end
         S_DFIX: begin
            // Negative partial remainder is restored once at the end
            c_nxt[C_ADD] = bus.a_msb;
            state_nxt = S_OUT_HI;
         end
         S_OUT_HI: begin
            c_nxt[C_OUT_A] = 1'b1;
            if (op == OP_ADD || op == OP_SUB) begin
               fin_nxt   = 1'b1;
               state_nxt = S_IDLE;
            end else begin
               state_nxt = S_OUT_LO;
            end
         end
         S_OUT_LO: begin
            c_nxt[C_OUT_Q] = 1'b1;
            fin_nxt   = 1'b1;
            state_nxt = S_IDLE;
         end
         S_ERR: begin
            fin_nxt   = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign bus.c      = c_nxt;
   assign bus.finish = fin_nxt;
   assign bus.busy   = (state != S_IDLE);
`ifdef ALU_SEQ_DIVZERO_EN
   assign bus.div_err = (state == S_ERR);
`endif
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: WIDTH=8 and WIDTH=4 instances driven with identical stimulus.
// ALU_SEQ_DIVZERO_EN enables the divide-by-zero checks.
module tb_alu_seq_ctrl;
   localparam int NCYC = 36;
   localparam int M_NONE = 0, M_MUL = 1, M_DIV1 = 2, M_DIV0 = 3, M_JUNK = 4, M_B2B = 5;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_seq_ctrl_if bus8 ();
   alu_seq_ctrl_if bus4 ();

   alu_seq_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
   alu_seq_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

   int n_checks = 0;
   int n_fail   = 0;

   logic [11:0] c8_tr   [0:NCYC-1];
   logic        fin8_tr [0:NCYC-1];
   logic        busy8_tr[0:NCYC-1];
   logic [2:0]  cnt8_tr [0:NCYC-1];
   logic        err8_tr [0:NCYC-1];
   logic        fin4_tr [0:NCYC-1];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic st, input logic [1:0] op, input logic q0, input logic qm1,
                        input logic am, input logic mz);
      bus8.start = st;  bus4.start = st;
      bus8.op_codes = op;  bus4.op_codes = op;
      bus8.q_zero = q0;  bus4.q_zero = q0;
      bus8.q_minus_one = qm1;  bus4.q_minus_one = qm1;
      bus8.a_msb = am;  bus4.a_msb = am;
`ifdef ALU_SEQ_DIVZERO_EN
      bus8.m_zero = mz;  bus4.m_zero = mz;
`else
      if (mz) begin end
`endif
   endtask

   // Booth pattern for MSTEP number i: 10, 01, 00, 11
   function automatic logic [1:0] booth_pat(input int i);
      case (i % 4)
         0: return 2'b10;
         1: return 2'b01;
         2: return 2'b00;
         default: return 2'b11;
      endcase
   endfunction

   // Expected WIDTH=8 MUL strobes for the pattern above
   function automatic logic [11:0] mul_exp(input int t);
      if (t == 1) return 12'h807;
      if (t >= 2 && t <= 17) begin
         if ((t % 2) == 1) return 12'h120;
         case (((t - 2) / 2) % 4)
            0: return 12'h010;
            1: return 12'h008;
            default: return 12'h000;
         endcase
      end
      if (t == 18) return 12'h200;
      if (t == 19) return 12'h400;
      return 12'h000;
   endfunction

   function automatic int first_fin8();
      for (int t = 0; t < NCYC; t++) if (fin8_tr[t]) return t;
      return -1;
   endfunction

   function automatic int first_fin4();
      for (int t = 0; t < NCYC; t++) if (fin4_tr[t]) return t;
      return -1;
   endfunction

   task automatic run(input logic [1:0] op, input int mode, input int rst_at, input logic mz);
      logic [1:0] bp;
      logic       st;
      logic [1:0] opv;
      logic       am;
      for (int t = 0; t < NCYC; t++) begin
         @(negedge clk);
         bp  = (t >= 2) ? booth_pat((t - 2) / 2) : 2'b00;
         st  = (t == 0) || (mode == M_JUNK && t >= 2 && t <= 17 && (t % 3) == 0)
               || (mode == M_B2B && t == 4);
         opv = (mode == M_JUNK && t != 0) ? 2'(t) : op;
         am  = (mode == M_DIV1);
         drive(st, opv, bp[1], bp[0], am, mz);
         rst = (t == rst_at);
         #1;
         c8_tr[t]    = bus8.c;
         fin8_tr[t]  = bus8.finish;
         busy8_tr[t] = bus8.busy;
         cnt8_tr[t]  = dut8.cnt;
         fin4_tr[t]  = bus4.finish;
`ifdef ALU_SEQ_DIVZERO_EN
         err8_tr[t]  = bus8.div_err;
`else
         err8_tr[t]  = 1'b0;
`endif
      end
      @(negedge clk);
      drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int cnt_inc;
      logic [11:0] acc;
      rst = 1'b1;
      drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 32'(bus8.busy), 32'd0);
      check("rst_finish", 32'(bus8.finish), 32'd0);
      check("rst_c", 32'(bus8.c), 32'd0);
      check("rst_cnt", 32'(dut8.cnt), 32'd0);
      rst = 1'b0;

      // ADD
      run(2'b00, M_NONE, -1, 1'b0);
      check("add_busy0", 32'(busy8_tr[0]), 32'd0);
      check("add_c1", 32'(c8_tr[1]), 32'h807);
      check("add_c2", 32'(c8_tr[2]), 32'h008);
      check("add_c3", 32'(c8_tr[3]), 32'h200);
      check("add_fin", 32'(first_fin8()), 32'd3);
      for (int t = 1; t <= 3; t++) check($sformatf("add_busy%0d", t), 32'(busy8_tr[t]), 32'd1);
      check("add_busy4", 32'(busy8_tr[4]), 32'd0);

      // SUB
      run(2'b01, M_NONE, -1, 1'b0);
      check("sub_c2", 32'(c8_tr[2]), 32'h010);
      check("sub_fin", 32'(first_fin8()), 32'd3);

      // MUL with cyclic Booth pattern
      run(2'b10, M_MUL, -1, 1'b0);
      cnt_inc = 0;
      for (int t = 0; t < NCYC; t++) begin
         check($sformatf("mul_c%0d", t), 32'(c8_tr[t]), 32'(mul_exp(t)));
         if (c8_tr[t][8]) cnt_inc++;
      end
      check("mul_c8_pulses", 32'(cnt_inc), 32'd8);
      check("mul_fin", 32'(first_fin8()), 32'd19);
      check("mul_fin_w4", 32'(first_fin4()), 32'd11);
      check("mul_cnt_wrap", 32'(cnt8_tr[18]), 32'd0);

      // MUL with stray start pulses and op changes
      run(2'b10, M_JUNK, -1, 1'b0);
      for (int t = 0; t < 22; t++)
         check($sformatf("junk_c%0d", t), 32'(c8_tr[t]), 32'(mul_exp(t)));
      check("junk_fin", 32'(first_fin8()), 32'd19);

      // DIV with negative remainder every step
      run(2'b11, M_DIV1, -1, 1'b0);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("div1_shl%0d", i), 32'(c8_tr[2 + 3 * i]), 32'h040);
         check($sformatf("div1_dop%0d", i), 32'(c8_tr[3 + 3 * i]), 32'h008);
         check($sformatf("div1_dset%0d", i), 32'(c8_tr[4 + 3 * i]), 32'h100);
      end
      check("div1_dfix", 32'(c8_tr[26]), 32'h008);
      check("div1_outhi", 32'(c8_tr[27]), 32'h200);
      check("div1_outlo", 32'(c8_tr[28]), 32'h400);
      check("div1_fin", 32'(first_fin8()), 32'd28);
      check("div1_fin_w4", 32'(first_fin4()), 32'd16);

      // DIV with non-negative remainder every step
      run(2'b11, M_DIV0, -1, 1'b0);
      check("div0_dop", 32'(c8_tr[3]), 32'h010);
      check("div0_dset", 32'(c8_tr[4]), 32'h180);
      check("div0_dfix", 32'(c8_tr[26]), 32'h000);
      check("div0_fin", 32'(first_fin8()), 32'd28);

      // Back-to-back ADDs
      run(2'b00, M_B2B, -1, 1'b0);
      check("b2b_fin1", 32'(fin8_tr[3]), 32'd1);
      check("b2b_idle", 32'(busy8_tr[4]), 32'd0);
      check("b2b_init", 32'(c8_tr[5]), 32'h807);
      check("b2b_fin2", 32'(fin8_tr[7]), 32'd1);

      // Reset in the middle of a MUL
      run(2'b10, M_MUL, 7, 1'b0);
      check("mrst_busy", 32'(busy8_tr[8]), 32'd0);
      check("mrst_c", 32'(c8_tr[8]), 32'd0);
      check("mrst_cnt", 32'(cnt8_tr[8]), 32'd0);
      check("mrst_nofin", 32'(first_fin8()), 32'hFFFF_FFFF);
      run(2'b00, M_NONE, -1, 1'b0);
      check("mrst_add_fin", 32'(first_fin8()), 32'd3);

`ifdef ALU_SEQ_DIVZERO_EN
      run(2'b11, M_NONE, -1, 1'b1);
      acc = '0;
      for (int t = 0; t < NCYC; t++) acc |= c8_tr[t];
      check("dz_fin", 32'(first_fin8()), 32'd2);
      check("dz_err", 32'(err8_tr[2]), 32'd1);
      check("dz_err_off", 32'(err8_tr[3]), 32'd0);
      check("dz_c2", 32'(c8_tr[2]), 32'd0);
      check("dz_no_alu", 32'(acc & 12'h718), 32'd0);
      run(2'b11, M_DIV1, -1, 1'b0);
      check("dz_ok_fin", 32'(first_fin8()), 32'd28);
      check("dz_ok_err", 32'(err8_tr[28]), 32'd0);
`else
      acc = '0;
      if (acc != 0) begin end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
